regfile_ckpt: RTL and testbench
===============================

// Module: regfile_ckpt
// PURPOSE
//  Architectural register file plus rename table (busy + ROB tag per register).
//  Generalises the flat regfile in three ways: parametrised width and depth,
//  same-cycle commit bypass on both read ports, and CKPT_CNT rename-table
//  snapshots taken at branch dispatch.
//  Sits between dispatcher and ROB. A mispredict restores one checkpoint
//  instead of a full flush.
// PARAMETERS
//  DATA_W   32  register value width
//  REG_CNT  32  architectural register count (x0 hardwired zero)
//  REG_W     5  register index width, clog2(REG_CNT)
//  ROB_W     4  ROB tag width
//  CKPT_CNT  4  snapshot slots, power of two
//  CKPT_W    2  clog2(CKPT_CNT)
// PORTS
//  clk_in                             in   1       clock
//  rst_in                             in   1       reset, synchronous, active-high
//  rdy_in                             in   1       low: hold all state
//  dispatcher_regfile_rs_in           in   REG_W   source A index
//  regfile_dispatcher_rs_busy_out     out  1       source A pending in ROB
//  regfile_dispatcher_rs_out          out  DATA_W  source A committed value
//  regfile_dispatcher_rs_reorder_out  out  ROB_W   source A producer tag
//  dispatcher_regfile_rt_in / regfile_dispatcher_rt_{busy,,reorder}_out
//                                                  source B, same as source A
//  dispatcher_regfile_rd_en_in        in   1       rename rd this cycle
//  dispatcher_regfile_rd_in           in   REG_W   destination index
//  dispatcher_regfile_reorder_in      in   ROB_W   tag assigned to rd
//  dispatcher_regfile_ckpt_en_in      in   1       take snapshot (branch/jump)
//  regfile_dispatcher_ckpt_id_out     out  CKPT_W  slot the next take fills (tail)
//  regfile_dispatcher_ckpt_full_out   out  1       all slots in use
//  rob_regfile_en_in                  in   1       commit writeback
//  rob_regfile_d_in                   in   REG_W   commit destination
//  rob_regfile_value_in               in   DATA_W  commit value
//  rob_regfile_h_in                   in   ROB_W   committing tag (ROB head)
//  rob_regfile_rst_in                 in   1       full flush
//  rob_regfile_ckpt_free_in           in   1       oldest branch retired; pop head slot
//  rob_regfile_recover_in             in   1       mispredict; restore a slot
//  rob_regfile_recover_id_in          in   CKPT_W  slot to restore
// BEHAVIOUR
//  - Reset: all values, busy and reorder cleared; head = tail = count = 0.
//    Outputs therefore read 0, ckpt_id_out = 0, full = 0.
//  - Reads are combinational.
//    x0 always reads busy 0, value 0, reorder 0.
//    Bypass: if rdy_in, rob_regfile_en_in, d == src != 0, busy[src] and
//    reorder[src] == h, the port shows busy 0 and value = rob_regfile_value_in.
//    Otherwise the port shows the table entry.
//  - Commit (rdy, en, d != 0): register[d] <= value, always.
//    Any entry whose tag equals h gets busy 0 and reorder 0. This applies to:
//    live[d], the restored image on a recover cycle, and every valid snapshot.
//  - Per-cycle priority: rst_in > rob_regfile_rst_in > recover > dispatch
//    (rename and take).
//    The commit value write is independent of this priority and always occurs.
//  - Rename (rd_en, rd != 0, no flush/recover): busy[rd] <= 1,
//    reorder[rd] <= tag. Rename wins over a commit clear on the same rd.
//  - Take (ckpt_en, !full, no flush/recover): snapshot[tail] <= next-state live
//    table, i.e. including same-cycle rename and commit clears.
//    Then tail++ (wraps), count++.
//    Take while full is ignored; the dispatcher must stall.
//  - Free: head++ and count--. Ignored if count == 0.
//  - Recover(id): live busy/reorder <= snapshot[id], with same-cycle commit
//    clear applied. tail <= id+1, so id and all older slots are retained.
//    count <= id - head + 1 (mod, plus free adjustment).
//    Slots younger than id are discarded. Recovering an invalid id is illegal.
//  - Flush: all busy/reorder cleared, head = tail = count = 0.
//    Register values are kept.
//  - full_out = (count == CKPT_CNT), registered. ckpt_id_out = tail.
// TESTING
//  1. Reset: rs=3, rt=0 -> busy 0, value 0, reorder 0; full 0; ckpt_id 0.
//  2. Rename x5 tag 3; next cycle commit x5 h=3 val 0x1234 -> same cycle rs=5
//     reads busy 0, value 0x1234; next cycle table busy 0.
//  3. Rename x5 tag 3, then x5 tag 7; commit x5 h=3 val 9 -> value 9,
//     busy 1, reorder 7.
//  4. Rename x1 tag1. Take (id 0) with same-cycle rename x2 tag2.
//     Rename x1 tag4, take (id 1). Recover id 0 -> x1 reorder 1,
//     x2 busy reorder 2, ckpt_id_out 1.
//  5. x3 busy tag5, take id 0; commit x3 h=5; recover 0 -> x3 busy 0.
//  6. CKPT_CNT takes -> full 1; extra take ignored (ckpt_id unchanged);
//     free -> full 0; rob_regfile_rst_in -> all busy 0, ckpt_id 0, values kept.

Source files
------------

// File: rtl/regfile_ckpt.sv
// Architectural register file plus rename table with CKPT_CNT branch snapshots and commit bypass.
// Latency: reads are combinational; rename/commit/take/recover become visible one cycle later.
// Backpressure: rdy_in low holds all state; a take while full is dropped, so the dispatcher must stall.
module regfile_ckpt #(
    parameter int DATA_W   = 32,
    parameter int REG_CNT  = 32,
    parameter int REG_W    = 5,
    parameter int ROB_W    = 4,
    parameter int CKPT_CNT = 4,
    parameter int CKPT_W   = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [REG_W-1:0]  dispatcher_regfile_rs_in,
    output logic              regfile_dispatcher_rs_busy_out,
    output logic [DATA_W-1:0] regfile_dispatcher_rs_out,
    output logic [ROB_W-1:0]  regfile_dispatcher_rs_reorder_out,
    input  logic [REG_W-1:0]  dispatcher_regfile_rt_in,
    output logic              regfile_dispatcher_rt_busy_out,
    output logic [DATA_W-1:0] regfile_dispatcher_rt_out,
    output logic [ROB_W-1:0]  regfile_dispatcher_rt_reorder_out,
    input  logic              dispatcher_regfile_rd_en_in,
    input  logic [REG_W-1:0]  dispatcher_regfile_rd_in,
    input  logic [ROB_W-1:0]  dispatcher_regfile_reorder_in,
    input  logic              dispatcher_regfile_ckpt_en_in,
    output logic [CKPT_W-1:0] regfile_dispatcher_ckpt_id_out,
    output logic              regfile_dispatcher_ckpt_full_out,
    input  logic              rob_regfile_en_in,
    input  logic [REG_W-1:0]  rob_regfile_d_in,
    input  logic [DATA_W-1:0] rob_regfile_value_in,
    input  logic [ROB_W-1:0]  rob_regfile_h_in,
    input  logic              rob_regfile_rst_in,
    input  logic              rob_regfile_ckpt_free_in,
    input  logic              rob_regfile_recover_in,
    input  logic [CKPT_W-1:0] rob_regfile_recover_id_in
);

    localparam int CNT_W = CKPT_W + 1;

    typedef struct packed {
        logic              busy;
        logic [ROB_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } rd_t;

    logic [DATA_W-1:0]  val_q   [REG_CNT];
    logic [DATA_W-1:0]  val_d   [REG_CNT];
    logic [REG_CNT-1:0] busy_q, busy_d;
    logic [ROB_W-1:0]   tag_q   [REG_CNT];
    logic [ROB_W-1:0]   tag_d   [REG_CNT];
    logic [REG_CNT-1:0] sbusy_q [CKPT_CNT];
    logic [REG_CNT-1:0] sbusy_d [CKPT_CNT];
    logic [ROB_W-1:0]   stag_q  [CKPT_CNT][REG_CNT];
    logic [ROB_W-1:0]   stag_d  [CKPT_CNT][REG_CNT];
    logic [CKPT_W-1:0]  head_q, head_d;
    logic [CKPT_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               full_q, full_d;

    logic               commit, flush, recover, dispatch, take, free, rename;
    logic [CKPT_W-1:0]  rec_span;
    rd_t                rs_rd, rt_rd;

    // A committing tag can only live in entry d, so only that entry is matched.
    function automatic rd_t read_port(input logic [REG_W-1:0] src);
        rd_t r;
        r = '0;
        if (src != '0) begin
            if (rdy_in && rob_regfile_en_in && rob_regfile_d_in == src &&
                busy_q[src] && tag_q[src] == rob_regfile_h_in) begin
                r.val = rob_regfile_value_in;
            end else begin
                r.busy = busy_q[src];
                r.tag  = tag_q[src];
                r.val  = val_q[src];
            end
        end
        return r;
    endfunction

    always_comb begin
        rs_rd = read_port(dispatcher_regfile_rs_in);
        rt_rd = read_port(dispatcher_regfile_rt_in);
    end

    assign regfile_dispatcher_rs_busy_out    = rs_rd.busy;
    assign regfile_dispatcher_rs_out         = rs_rd.val;
    assign regfile_dispatcher_rs_reorder_out = rs_rd.tag;
    assign regfile_dispatcher_rt_busy_out    = rt_rd.busy;
    assign regfile_dispatcher_rt_out         = rt_rd.val;
    assign regfile_dispatcher_rt_reorder_out = rt_rd.tag;
    assign regfile_dispatcher_ckpt_id_out    = tail_q;
    assign regfile_dispatcher_ckpt_full_out  = full_q;

    always_comb begin
        val_d    = val_q;
        busy_d   = busy_q;
        tag_d    = tag_q;
        sbusy_d  = sbusy_q;
        stag_d   = stag_q;
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        rec_span = rob_regfile_recover_id_in - head_q;

        commit   = rdy_in && rob_regfile_en_in && (rob_regfile_d_in != '0);
        flush    = rdy_in && rob_regfile_rst_in;
        recover  = rdy_in && !flush && rob_regfile_recover_in;
        dispatch = rdy_in && !flush && !recover;
        take     = dispatch && dispatcher_regfile_ckpt_en_in && !full_q;
        free     = rdy_in && rob_regfile_ckpt_free_in && (cnt_q != '0);
        rename   = dispatch && dispatcher_regfile_rd_en_in && (dispatcher_regfile_rd_in != '0);

        if (commit) begin
            val_d[rob_regfile_d_in] = rob_regfile_value_in;
            if (tag_q[rob_regfile_d_in] == rob_regfile_h_in) begin
                busy_d[rob_regfile_d_in] = 1'b0;
                tag_d[rob_regfile_d_in]  = '0;
            end
            for (int s = 0; s < CKPT_CNT; s++) begin
                if (stag_q[s][rob_regfile_d_in] == rob_regfile_h_in) begin
                    sbusy_d[s][rob_regfile_d_in] = 1'b0;
                    stag_d[s][rob_regfile_d_in]  = '0;
                end
            end
        end

        if (flush) begin
            busy_d = '0;
            for (int r = 0; r < REG_CNT; r++) begin
                tag_d[r] = '0;
            end
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else if (recover) begin
            // Restored image already carries this cycle's commit clear.
            busy_d = sbusy_d[rob_regfile_recover_id_in];
            tag_d  = stag_d[rob_regfile_recover_id_in];
            tail_d = rob_regfile_recover_id_in + CKPT_W'(1);
            head_d = head_q + CKPT_W'(free);
            cnt_d  = CNT_W'(rec_span) + CNT_W'(1) - CNT_W'(free);
        end else begin
            if (rename) begin
                busy_d[dispatcher_regfile_rd_in] = 1'b1;
                tag_d[dispatcher_regfile_rd_in]  = dispatcher_regfile_reorder_in;
            end
            if (take) begin
                sbusy_d[tail_q] = busy_d;
                stag_d[tail_q]  = tag_d;
                tail_d          = tail_q + CKPT_W'(1);
            end
            head_d = head_q + CKPT_W'(free);
            cnt_d  = cnt_q + CNT_W'(take) - CNT_W'(free);
        end

        full_d = (cnt_d == CNT_W'(CKPT_CNT));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int r = 0; r < REG_CNT; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
            busy_q <= '0;
            for (int s = 0; s < CKPT_CNT; s++) begin
                sbusy_q[s] <= '0;
                for (int r = 0; r < REG_CNT; r++) begin
                    stag_q[s][r] <= '0;
                end
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            val_q   <= val_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
            sbusy_q <= sbusy_d;
            stag_q  <= stag_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: tb/tb_regfile_ckpt.sv
// Directed bench for regfile_ckpt: a queue-of-snapshots model checked every cycle, plus literal spot checks.
module tb_regfile_ckpt;

    logic        clk;
    logic        rst, rdy;
    logic [4:0]  rs, rt;
    logic        rs_busy, rt_busy;
    logic [31:0] rs_val, rt_val;
    logic [3:0]  rs_tag, rt_tag;
    logic        rd_en, ckpt_en;
    logic [4:0]  rd;
    logic [3:0]  rd_tag;
    logic [1:0]  ckpt_id;
    logic        ckpt_full;
    logic        c_en;
    logic [4:0]  c_d;
    logic [31:0] c_val;
    logic [3:0]  c_h;
    logic        flush_in, free_in, rec_in;
    logic [1:0]  rec_id;

    int n_chk  = 0;
    int n_pass = 0;

    regfile_ckpt dut (
        .clk_in                            (clk),
        .rst_in                            (rst),
        .rdy_in                            (rdy),
        .dispatcher_regfile_rs_in          (rs),
        .regfile_dispatcher_rs_busy_out    (rs_busy),
        .regfile_dispatcher_rs_out         (rs_val),
        .regfile_dispatcher_rs_reorder_out (rs_tag),
        .dispatcher_regfile_rt_in          (rt),
        .regfile_dispatcher_rt_busy_out    (rt_busy),
        .regfile_dispatcher_rt_out         (rt_val),
        .regfile_dispatcher_rt_reorder_out (rt_tag),
        .dispatcher_regfile_rd_en_in       (rd_en),
        .dispatcher_regfile_rd_in          (rd),
        .dispatcher_regfile_reorder_in     (rd_tag),
        .dispatcher_regfile_ckpt_en_in     (ckpt_en),
        .regfile_dispatcher_ckpt_id_out    (ckpt_id),
        .regfile_dispatcher_ckpt_full_out  (ckpt_full),
        .rob_regfile_en_in                 (c_en),
        .rob_regfile_d_in                  (c_d),
        .rob_regfile_value_in              (c_val),
        .rob_regfile_h_in                  (c_h),
        .rob_regfile_rst_in                (flush_in),
        .rob_regfile_ckpt_free_in          (free_in),
        .rob_regfile_recover_in            (rec_in),
        .rob_regfile_recover_id_in         (rec_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    int mval [32];
    bit mb   [32];
    int mt   [32];
    bit sb   [4][32];
    int st   [4][32];
    int live_slots [$];
    int nxt_slot;
    bit chk_en = 0;

    always @(posedge clk) begin
        bit free_ok;
        chk_en = 1;
        if (rst) begin
            for (int r = 0; r < 32; r++) begin mval[r] = 0; mb[r] = 0; mt[r] = 0; end
            live_slots.delete();
            nxt_slot = 0;
        end else if (rdy) begin
            free_ok = free_in && live_slots.size() > 0;
            if (c_en && c_d != 0) begin
                mval[c_d] = c_val;
                if (mt[c_d] == c_h) begin mb[c_d] = 0; mt[c_d] = 0; end
                foreach (live_slots[i])
                    if (st[live_slots[i]][c_d] == c_h) begin
                        sb[live_slots[i]][c_d] = 0;
                        st[live_slots[i]][c_d] = 0;
                    end
            end
            if (flush_in) begin
                for (int r = 0; r < 32; r++) begin mb[r] = 0; mt[r] = 0; end
                live_slots.delete();
                nxt_slot = 0;
            end else if (rec_in) begin
                for (int r = 0; r < 32; r++) begin mb[r] = sb[rec_id][r]; mt[r] = st[rec_id][r]; end
                while (live_slots.size() > 0 && live_slots[$] != int'(rec_id))
                    void'(live_slots.pop_back());
                nxt_slot = (int'(rec_id) + 1) % 4;
                if (free_ok) void'(live_slots.pop_front());
            end else begin
                if (rd_en && rd != 0) begin mb[rd] = 1; mt[rd] = rd_tag; end
                if (ckpt_en && live_slots.size() < 4) begin
                    for (int r = 0; r < 32; r++) begin sb[nxt_slot][r] = mb[r]; st[nxt_slot][r] = mt[r]; end
                    live_slots.push_back(nxt_slot);
                    nxt_slot = (nxt_slot + 1) % 4;
                end
                if (free_ok) void'(live_slots.pop_front());
            end
        end
    end

    task automatic cmp_port(input string p, input logic [4:0] src,
                            input logic b, input logic [31:0] v, input logic [3:0] t);
        bit eb; int ev; int et;
        eb = 0; ev = 0; et = 0;
        if (src != 0) begin
            if (rdy && c_en && c_d == src && mb[src] && mt[src] == c_h) ev = c_val;
            else begin eb = mb[src]; ev = mval[src]; et = mt[src]; end
        end
        check({p, "_busy"}, 32'(b), 32'(eb));
        check({p, "_val"},  v, ev);
        check({p, "_tag"},  32'(t), 32'(et));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_port("rs", rs, rs_busy, rs_val, rs_tag);
            cmp_port("rt", rt, rt_busy, rt_val, rt_tag);
            check("ckpt_id", 32'(ckpt_id), 32'(nxt_slot));
            check("ckpt_full", 32'(ckpt_full), 32'(live_slots.size() == 4));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_in();
        rdy = 1; rd_en = 0; rd = 0; rd_tag = 0; ckpt_en = 0;
        c_en = 0; c_d = 0; c_val = 0; c_h = 0;
        flush_in = 0; free_in = 0; rec_in = 0; rec_id = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        idle_in();
    endtask

    task automatic ren(input logic [4:0] r, input logic [3:0] t);
        rd_en = 1; rd = r; rd_tag = t;
    endtask

    task automatic cmt(input logic [4:0] d, input logic [3:0] h, input logic [31:0] v);
        c_en = 1; c_d = d; c_h = h; c_val = v;
    endtask

    initial begin
        idle_in();
        rst = 1; rs = 3; rt = 0;
        step(); step();
        @(negedge clk);
        check("rst_rs_busy", 32'(rs_busy), 0);
        check("rst_rs_val", rs_val, 0);
        check("rst_rt_tag", 32'(rt_tag), 0);
        check("rst_full", 32'(ckpt_full), 0);
        check("rst_id", 32'(ckpt_id), 0);
        step();
        rst = 0;

        // commit bypass
        ren(5, 3); step();
        cmt(5, 3, 32'h1234); rs = 5;
        @(negedge clk);
        check("byp_busy", 32'(rs_busy), 0);
        check("byp_val", rs_val, 32'h1234);
        step();
        @(negedge clk);
        check("cmt_busy", 32'(rs_busy), 0);
        check("cmt_val", rs_val, 32'h1234);
        step();

        // older commit must not clear a newer rename
        ren(5, 3); step();
        ren(5, 7); step();
        cmt(5, 3, 9); step();
        @(negedge clk);
        check("stale_val", rs_val, 9);
        check("stale_busy", 32'(rs_busy), 1);
        check("stale_tag", 32'(rs_tag), 7);
        step();

        // take with same-cycle rename, then recover slot 0
        ren(1, 1); step();
        ren(2, 2); ckpt_en = 1; step();
        ren(1, 4); ckpt_en = 1; step();
        rs = 1; rt = 2;
        @(negedge clk);
        check("pre_rec_tag", 32'(rs_tag), 4);
        check("pre_rec_id", 32'(ckpt_id), 2);
        step();
        rec_in = 1; rec_id = 0; step();
        @(negedge clk);
        check("rec_x1_tag", 32'(rs_tag), 1);
        check("rec_x2_busy", 32'(rt_busy), 1);
        check("rec_x2_tag", 32'(rt_tag), 2);
        check("rec_id", 32'(ckpt_id), 1);
        step();

        // commit clears snapshot entry before recover
        flush_in = 1; step();
        ren(3, 5); step();
        ckpt_en = 1; step();
        cmt(3, 5, 32'h55); step();
        rec_in = 1; rec_id = 0; rs = 3; step();
        @(negedge clk);
        check("snapclr_busy", 32'(rs_busy), 0);
        check("snapclr_val", rs_val, 32'h55);
        step();

        // rdy low freezes everything
        rdy = 0; ren(6, 2); ckpt_en = 1; cmt(7, 0, 32'hdead); rs = 6; rt = 7;
        step();
        @(negedge clk);
        check("hold_busy", 32'(rs_busy), 0);
        check("hold_val", rt_val, 0);
        check("hold_id", 32'(ckpt_id), 1);
        step();

        // fill, overflow, free, partial recover with free, flush
        flush_in = 1; step();
        for (int i = 0; i < 4; i++) begin
            ren(5'(10 + i), 4'(i + 1)); ckpt_en = 1; step();
        end
        rs = 12; rt = 13;
        @(negedge clk);
        check("full_set", 32'(ckpt_full), 1);
        check("full_id", 32'(ckpt_id), 0);
        step();
        ren(20, 9); ckpt_en = 1; step();
        @(negedge clk);
        check("ovf_id", 32'(ckpt_id), 0);
        check("ovf_full", 32'(ckpt_full), 1);
        step();
        free_in = 1; step();
        @(negedge clk);
        check("free_full", 32'(ckpt_full), 0);
        step();
        ren(12, 15); step();
        rec_in = 1; rec_id = 2; free_in = 1; step();
        @(negedge clk);
        check("rec2_id", 32'(ckpt_id), 3);
        check("rec2_x12_tag", 32'(rs_tag), 3);
        check("rec2_x13_busy", 32'(rt_busy), 0);
        step();
        flush_in = 1; step();
        for (int r = 1; r < 32; r++) begin
            rs = 5'(r); #1;
            check("flush_busy", 32'(rs_busy), 0);
        end
        rs = 5; rt = 3;
        @(negedge clk);
        check("flush_keep5", rs_val, 9);
        check("flush_keep3", rt_val, 32'h55);
        check("flush_id", 32'(ckpt_id), 0);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
